// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit: state encoding,
// strobe/finish polarities and the default wait budget per byte beat.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

  // pcir_cs is active-low
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam logic FULL  = 1'b1;
  localparam logic EMPTY = 1'b0;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int BEATS              = 4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_timer.sv
// Per-beat wait counter: counts consecutive ready-low cycles and flags the
// cycle on which one more stall would hit the timeout budget.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  // Stall number TIMEOUT_CYCLES is the one seen while the count is one short.
  assign w_at_limit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_expire   = i_inc && w_at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads a 32-bit word one byte at a time (big-endian)
// from byte-wide memory and presents it to the PC unit until a new PC arrives.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcir_cs,
  input  logic [31:0] program_count,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] opcode,
  output logic        finish,
  output logic        fetch_err
);

  fetch_state_e r_state, w_state_nxt;

  logic [31:0] r_base;
  logic [1:0]  r_beat;
  logic [23:0] r_buf;
  logic [31:0] r_opcode;

  logic w_latch;
  logic w_capture;
  logic w_last_beat;
  logic w_tmr_clear;
  logic w_tmr_inc;
  logic w_expire;

  assign w_last_beat = (r_beat == 2'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= START;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      START: begin
        w_latch     = 1'b1;
        w_state_nxt = is_word_aligned(program_count) ? FETCH : ERR;
      end
      FETCH: begin
        if (mem_ready) begin
          w_capture = 1'b1;
          if (w_last_beat) w_state_nxt = HOLD;
        end else if (w_expire) begin
          w_state_nxt = ERR;
        end
      end
      HOLD: begin
        // Same PC re-strobed means a two-step branch still needs this opcode.
        if (pcir_cs == INACTIVE)         w_state_nxt = HOLD;
        else if (program_count != r_base) w_state_nxt = START;
      end
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base   <= '0;
      r_beat   <= '0;
      r_buf    <= '0;
      r_opcode <= '0;
    end else begin
      if (w_latch) begin
        r_base <= program_count;
        r_beat <= '0;
      end else if (w_capture) begin
        r_beat <= r_beat + 2'd1;
      end
      if (w_capture) begin
        // Earlier beats shift toward the MSB, so beat0 ends in [31:24].
        r_buf <= {r_buf[15:0], mem_rdata};
        if (w_last_beat) r_opcode <= {r_buf, mem_rdata};
      end
    end
  end

  assign w_tmr_clear = (r_state != FETCH) || mem_ready;
  assign w_tmr_inc   = (r_state == FETCH) && !mem_ready;

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_tmr_clear),
    .i_inc   (w_tmr_inc),
    .o_expire(w_expire)
  );

  assign mem_addr  = r_base + {30'd0, r_beat};
  assign mem_rd    = (r_state == FETCH);
  assign opcode    = r_opcode;
  assign finish    = (r_state == HOLD) ? FULL : EMPTY;
  assign fetch_err = (r_state == ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte memory model, hand-computed opcodes,
// per-scenario tasks with inline comparisons.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        pcir_cs;
  logic [31:0] program_count;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [31:0] opcode;
  logic        finish;
  logic        fetch_err;

  logic [7:0] tb_mem [16];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  instr_fetch #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcir_cs      (pcir_cs),
    .program_count(program_count),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .finish       (finish),
    .fetch_err    (fetch_err)
  );

  assign mem_rdata = (mem_addr < 32'd16) ? tb_mem[mem_addr[3:0]] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pcir_cs = 1'b1; program_count = 32'h0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tot_cnt++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %0b want 0", mem_rd); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'h0) $display("FAIL reset_opcode: got %h want 0", opcode); else pass_cnt++;
    tot_cnt++; if (finish !== 1'b0) $display("FAIL reset_finish: got %0b want 0", finish); else pass_cnt++;
    tot_cnt++; if (fetch_err !== 1'b0) $display("FAIL reset_fetch_err: got %0b want 0", fetch_err); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    tick(); // START latches PC 0
    tot_cnt++; if (mem_rd !== 1'b1) $display("FAIL basic_rd_c1: got %0b want 1", mem_rd); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 32'h0) $display("FAIL basic_addr_c1: got %h want 0", mem_addr); else pass_cnt++;
    tick();
    tot_cnt++; if (mem_addr !== 32'h1) $display("FAIL basic_addr_c2: got %h want 1", mem_addr); else pass_cnt++;
    tick(); tick();
    tot_cnt++; if (finish !== 1'b0) $display("FAIL basic_finish_c4: got %0b want 0", finish); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 32'h3) $display("FAIL basic_addr_c4: got %h want 3", mem_addr); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'h0) $display("FAIL basic_opcode_hold: got %h want 0", opcode); else pass_cnt++;
    tick();
    tot_cnt++; if (finish !== 1'b1) $display("FAIL basic_finish_c5: got %0b want 1", finish); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'h10220005) $display("FAIL basic_opcode: got %h want 10220005", opcode); else pass_cnt++;
    tot_cnt++; if (mem_rd !== 1'b0) $display("FAIL basic_rd_done: got %0b want 0", mem_rd); else pass_cnt++;
  endtask

  task automatic test_hold();
    pcir_cs = 1'b0; program_count = 32'h0;
    tick();
    tot_cnt++; if (finish !== 1'b1) $display("FAIL hold_same1: got %0b want 1", finish); else pass_cnt++;
    pcir_cs = 1'b1;
    tick();
    pcir_cs = 1'b0;
    tick();
    tot_cnt++; if (finish !== 1'b1) $display("FAIL hold_same2: got %0b want 1", finish); else pass_cnt++;
    pcir_cs = 1'b1; program_count = 32'h8;
    tick();
    tot_cnt++; if (finish !== 1'b1) $display("FAIL hold_cs_high: got %0b want 1", finish); else pass_cnt++;
    pcir_cs = 1'b0;
    tick();
    tot_cnt++; if (finish !== 1'b0) $display("FAIL hold_drop: got %0b want 0", finish); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'h10220005) $display("FAIL hold_opcode_keep: got %h want 10220005", opcode); else pass_cnt++;
    pcir_cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tot_cnt++;
      if (mem_rd !== 1'b1 || mem_addr !== 32'(8 + i))
        $display("FAIL hold_addr%0d: got rd=%0b addr=%h want rd=1 addr=%h", i, mem_rd, mem_addr, 32'(8 + i));
      else pass_cnt++;
    end
    tick();
    tot_cnt++; if (finish !== 1'b1) $display("FAIL hold_refetch_finish: got %0b want 1", finish); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'hA1B2C3D4) $display("FAIL hold_refetch_opcode: got %h want a1b2c3d4", opcode); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    pcir_cs = 1'b0; program_count = 32'h0;
    tick();
    pcir_cs = 1'b1;
    tick(); tick(); tick();
    tot_cnt++; if (mem_addr !== 32'h2 || mem_rd !== 1'b1) $display("FAIL rmid_beat2: got rd=%0b addr=%h want rd=1 addr=2", mem_rd, mem_addr); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    tot_cnt++; if (mem_rd !== 1'b0) $display("FAIL rmid_rd: got %0b want 0", mem_rd); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 32'h0) $display("FAIL rmid_addr: got %h want 0", mem_addr); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'h0) $display("FAIL rmid_opcode: got %h want 0", opcode); else pass_cnt++;
    tot_cnt++; if (finish !== 1'b0 || fetch_err !== 1'b0) $display("FAIL rmid_flags: got fin=%0b err=%0b want 0 0", finish, fetch_err); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) tick();
    tot_cnt++; if (finish !== 1'b0) $display("FAIL rmid_finish_c4: got %0b want 0", finish); else pass_cnt++;
    tick();
    tot_cnt++; if (finish !== 1'b1 || opcode !== 32'h10220005) $display("FAIL rmid_refetch: got fin=%0b op=%h want 1 10220005", finish, opcode); else pass_cnt++;
  endtask

  task automatic test_wait();
    pcir_cs = 1'b0; program_count = 32'h8;
    tick();
    pcir_cs = 1'b1;
    tick(); tick(); tick(); // latch, beat0, beat1
    mem_ready = 1'b0;
    repeat (3) tick();
    tot_cnt++; if (mem_addr !== 32'hA || mem_rd !== 1'b1) $display("FAIL wait_stall_addr: got rd=%0b addr=%h want rd=1 addr=a", mem_rd, mem_addr); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'h10220005) $display("FAIL wait_opcode_hold: got %h want 10220005", opcode); else pass_cnt++;
    mem_ready = 1'b1;
    tick();
    tot_cnt++; if (finish !== 1'b0 || mem_addr !== 32'hB) $display("FAIL wait_beat3: got fin=%0b addr=%h want 0 b", finish, mem_addr); else pass_cnt++;
    tick();
    tot_cnt++; if (finish !== 1'b1) $display("FAIL wait_finish: got %0b want 1", finish); else pass_cnt++;
    tot_cnt++; if (opcode !== 32'hA1B2C3D4) $display("FAIL wait_opcode: got %h want a1b2c3d4", opcode); else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic seen_rd;
    seen_rd = 1'b0;
    pcir_cs = 1'b0; program_count = 32'h6;
    tick();
    pcir_cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_rd !== 1'b0) seen_rd = 1'b1;
    end
    tot_cnt++; if (seen_rd !== 1'b0) $display("FAIL misalign_rd: got %0b want 0", seen_rd); else pass_cnt++;
    tot_cnt++; if (fetch_err !== 1'b1) $display("FAIL misalign_err: got %0b want 1", fetch_err); else pass_cnt++;
    tot_cnt++; if (finish !== 1'b0) $display("FAIL misalign_finish: got %0b want 0", finish); else pass_cnt++;
    pcir_cs = 1'b0; program_count = 32'h0;
    tick(); tick();
    pcir_cs = 1'b1;
    tot_cnt++; if (fetch_err !== 1'b1 || mem_rd !== 1'b0) $display("FAIL misalign_sticky: got err=%0b rd=%0b want 1 0", fetch_err, mem_rd); else pass_cnt++;
  endtask

  task automatic test_timeout();
    rst = 1'b0; program_count = 32'h0; pcir_cs = 1'b1; mem_ready = 1'b1;
    #1;
    tot_cnt++; if (fetch_err !== 1'b0) $display("FAIL timeout_rst_clr: got %0b want 0", fetch_err); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    tick(); tick(); // latch, beat0
    mem_ready = 1'b0;
    repeat (15) tick();
    tot_cnt++; if (fetch_err !== 1'b0 || mem_rd !== 1'b1) $display("FAIL timeout_15: got err=%0b rd=%0b want 0 1", fetch_err, mem_rd); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 32'h1) $display("FAIL timeout_addr: got %h want 1", mem_addr); else pass_cnt++;
    tick();
    tot_cnt++; if (fetch_err !== 1'b1 || mem_rd !== 1'b0) $display("FAIL timeout_16: got err=%0b rd=%0b want 1 0", fetch_err, mem_rd); else pass_cnt++;
    tot_cnt++; if (finish !== 1'b0) $display("FAIL timeout_finish: got %0b want 0", finish); else pass_cnt++;
    mem_ready = 1'b1;
    tick(); tick();
    tot_cnt++; if (fetch_err !== 1'b1) $display("FAIL timeout_sticky: got %0b want 1", fetch_err); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    tb_mem[0] = 8'h10; tb_mem[1] = 8'h22; tb_mem[2]  = 8'h00; tb_mem[3]  = 8'h05;
    tb_mem[8] = 8'hA1; tb_mem[9] = 8'hB2; tb_mem[10] = 8'hC3; tb_mem[11] = 8'hD4;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_wait();
    test_misalign();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
